// File: rtl/ex_issue_pkg.sv
// Shared definitions for the ex_issue stage: ALU opcodes, FSM state encoding,
// latency defaults and the multi-cycle opcode classifier.
package ex_issue_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 4;
    localparam int REG_W = 4;
    localparam int CTR_W = 4;

    localparam int MULDIV_CYCLES_DEF = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'h9;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'hA;
    localparam logic [OP_W-1:0] ALU_DIV  = 4'hB;
    localparam logic [OP_W-1:0] ALU_MOD  = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/ex_issue_if.sv
// Decode-side and writeback-side handshake bundle for ex_issue.
// slave = the issue stage, master = the decode/writeback environment.
interface ex_issue_if;
    import ex_issue_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [REG_W-1:0] in_rs1;
    logic [REG_W-1:0] in_rs2;
    logic [REG_W-1:0] in_rd;
    logic             in_we;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_y;
    logic             out_zero;
    logic [REG_W-1:0] out_rd;
    logic             out_we;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rs1, in_rs2, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rs1, in_rs2, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_rd, out_we
    );

endinterface

// File: rtl/ex_lat_ctr.sv
// Loadable down-counter timing how long operands stay on the ALU.
// Saturates at zero; zero flag is combinational from the count.
module ex_lat_ctr
    import ex_issue_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ex_issue.sv
// Issue stage: latches an op, holds it on the external ALU for its latency and
// presents the result on a valid/ready port. Optional forwarding: EX_ISSUE_FWD_EN.
//
// state | meaning
// IDLE  | nothing in flight, ready for a new op
// EXEC  | operands on the ALU, latency counter running
// DONE  | result held on out_*, waiting for out_ready
module ex_issue
    import ex_issue_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    ex_issue_if.slave       bus,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [XLEN-1:0] alu_y,
    input  logic            alu_zero
);

    localparam logic [CTR_W-1:0] MD_LOAD = CTR_W'(MULDIV_CYCLES - 1);

    ex_state_t        state_q, state_d;
    logic             ready, accept, capture;
    logic             ctr_zero;
    logic [CTR_W-1:0] ld_val;

    logic [OP_W-1:0]  op_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic [REG_W-1:0] rd_q;
    logic             we_q;
    logic [XLEN-1:0]  a_sel, b_sel;

    logic [XLEN-1:0]  y_q;
    logic             zero_q;
    logic [REG_W-1:0] out_rd_q;
    logic             out_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush overrides both a pending capture and any accept in the same cycle
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: ready = 1'b1;
            EXEC: begin
                if (ctr_zero) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            ready   = 1'b0;
            capture = 1'b0;
            state_d = IDLE;
        end
        accept = bus.in_valid & ready;
        if (accept) begin
            state_d = EXEC;
        end
    end

    assign ld_val = is_muldiv(bus.in_op) ? MD_LOAD : '0;

    ex_lat_ctr #(.W(CTR_W)) u_lat_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (accept),
        .load_val (ld_val),
        .dec      (state_q == EXEC),
        .zero     (ctr_zero)
    );

`ifdef EX_ISSUE_FWD_EN
    logic             fwd_valid;
    logic             fwd_we;
    logic [REG_W-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_y;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fwd_valid <= 1'b0;
            fwd_we    <= 1'b0;
            fwd_rd    <= '0;
            fwd_y     <= '0;
        end else if (capture) begin
            fwd_valid <= 1'b1;
            fwd_we    <= we_q;
            fwd_rd    <= rd_q;
            fwd_y     <= alu_y;
        end
    end

    // r0 is never a forwarding target
    assign a_sel = (fwd_valid && fwd_we && (fwd_rd != '0) && (bus.in_rs1 == fwd_rd)) ? fwd_y : bus.in_a;
    assign b_sel = (fwd_valid && fwd_we && (fwd_rd != '0) && (bus.in_rs2 == fwd_rd)) ? fwd_y : bus.in_b;
`else
    logic unused_rs;

    assign a_sel     = bus.in_a;
    assign b_sel     = bus.in_b;
    assign unused_rs = ^{bus.in_rs1, bus.in_rs2};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
            we_q <= 1'b0;
        end else if (accept) begin
            op_q <= bus.in_op;
            a_q  <= a_sel;
            b_q  <= b_sel;
            rd_q <= bus.in_rd;
            we_q <= bus.in_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            zero_q   <= 1'b0;
            out_rd_q <= '0;
            out_we_q <= 1'b0;
        end else if (capture) begin
            y_q      <= alu_y;
            zero_q   <= alu_zero;
            out_rd_q <= rd_q;
            out_we_q <= we_q;
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = y_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_we    = out_we_q;

endmodule
